rptr_empty_lvl: RTL and testbench



---
 rtl/rptr_empty_lvl.sv | 106 ++++++++++
 tb/tb_rptr_empty_lvl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_lvl.sv
// ----------------------------------------------------------------------------
// rptr_empty_lvl
//
// Read-side pointer and flag generator for an asynchronous FIFO. It lives in
// the read clock domain. It keeps a binary read counter and its Gray image.
// It compares the Gray image against the write pointer, which has already
// been synchronised into this domain. From that it produces registered
// empty, almost-empty, fill-level and sticky-underflow indications.
//
// Parameters
//   ADDR    memory address width, FIFO depth = 2**ADDR
//   AE_RST  value loaded into ralmost_empty by reset
//
// Ports
//   rclk           read-domain clock, all state on the rising edge
//   rrst           synchronous active-high reset
//   rinc           read request, honoured only while rempty is low
//   rq2_wptr       Gray write pointer, already synchronised into rclk
//   rae_thresh     almost-empty threshold (quasi-static)
//   ruf_clr        clears the sticky underflow flag
//   raddr          binary memory read address
//   rptr           Gray read pointer, sent to the write-domain synchroniser
//   rempty         FIFO empty (registered)
//   ralmost_empty  rlevel <= rae_thresh (registered)
//   rlevel         words available, 0 .. 2**ADDR (registered)
//   runderflow     sticky: a read was attempted while empty
// ----------------------------------------------------------------------------
module rptr_empty_lvl #(
    parameter int ADDR   = 4,
    parameter bit AE_RST = 1'b1
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic            rinc,
    input  logic [ADDR:0]   rq2_wptr,
    input  logic [ADDR:0]   rae_thresh,
    input  logic            ruf_clr,
    output logic [ADDR-1:0] raddr,
    output logic [ADDR:0]   rptr,
    output logic            rempty,
    output logic            ralmost_empty,
    output logic [ADDR:0]   rlevel,
    output logic            runderflow
);

    // Gray to binary conversion: bit i is the XOR of all Gray bits from the
    // MSB down to i.
    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR:0] rbin;
    logic [ADDR:0] rbinnext;
    logic [ADDR:0] rgraynext;
    logic [ADDR:0] rq2_wbin;
    logic [ADDR:0] level_next;
    logic          rd_take;

    // A read is accepted only when the FIFO is not empty. A read while empty
    // leaves the pointer where it is. It is counted as an underflow instead.
    assign rd_take    = rinc & ~rempty;
    assign rbinnext   = rbin + {{ADDR{1'b0}}, rd_take};
    assign rgraynext  = (rbinnext >> 1) ^ rbinnext;
    assign rq2_wbin   = gray2bin(rq2_wptr);
    // The subtraction wraps modulo 2**(ADDR+1). The extra MSB lets a full FIFO
    // (2**ADDR words) be told apart from an empty one.
    assign level_next = rq2_wbin - rbinnext;

    // The address comes straight from the counter register. This keeps the
    // memory read free of any added combinational delay.
    assign raddr = rbin[ADDR-1:0];

    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then sample the pre-edge values, whatever the statement order.
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= AE_RST;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            // Empty is a Gray-to-Gray compare. It is deliberately kept
            // independent of the converted level.
            rempty        <= (rgraynext == rq2_wptr);
            ralmost_empty <= (level_next <= rae_thresh);
            rlevel        <= level_next;
            // Set has priority over clear, so an underflow seen in the same
            // cycle as the clear is not lost.
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end else if (ruf_clr) begin
                runderflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// ----------------------------------------------------------------------------
// tb_rptr_empty_lvl
//
// Directed bench for rptr_empty_lvl with ADDR=4 and AE_RST=1. Inputs change
// 1 ns after the rising edge. Outputs are sampled at that same point, which
// is well clear of the next active edge.
// ----------------------------------------------------------------------------
module tb_rptr_empty_lvl;

    localparam int ADDR = 4;

    logic            rclk = 1'b0;
    logic            rrst;
    logic            rinc;
    logic [ADDR:0]   rq2_wptr;
    logic [ADDR:0]   rae_thresh;
    logic            ruf_clr;
    logic [ADDR-1:0] raddr;
    logic [ADDR:0]   rptr;
    logic            rempty;
    logic            ralmost_empty;
    logic [ADDR:0]   rlevel;
    logic            runderflow;

    int vectors    = 0;
    int miscompares = 0;

    rptr_empty_lvl #(.ADDR(ADDR), .AE_RST(1'b1)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .rae_thresh    (rae_thresh),
        .ruf_clr       (ruf_clr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR:0] gray(input int b);
        logic [ADDR:0] v;
        v = (ADDR+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rempty"},     int'(rempty), 1);
        check({tag, ".rlevel"},     int'(rlevel), 0);
        check({tag, ".raddr"},      int'(raddr), 0);
        check({tag, ".rptr"},       int'(rptr), 0);
        check({tag, ".runderflow"}, int'(runderflow), 0);
        check({tag, ".ralmost"},    int'(ralmost_empty), 1);
    endtask

    // Read-side model for the streaming section.
    int            wbin_m;
    int            rbin_m;
    int            lvl_m;
    bit            empty_m;
    bit            acc;
    logic [ADDR:0] prev_rptr;

    initial begin
        rrst       = 1'b1;
        rinc       = 1'b0;
        rq2_wptr   = '0;
        rae_thresh = '0;
        ruf_clr    = 1'b0;

        // Reset held for two edges, then idle.
        tick();
        tick();
        check_reset_state("reset");
        rrst = 1'b0;
        tick();
        check("idle.rempty", int'(rempty), 1);
        check("idle.rlevel", int'(rlevel), 0);
        check("idle.ralmost", int'(ralmost_empty), 1);

        // Fill to 5 words, then drain them.
        rq2_wptr = 5'b00111;
        tick();
        check("fill.rempty", int'(rempty), 0);
        check("fill.rlevel", int'(rlevel), 5);
        check("fill.ralmost", int'(ralmost_empty), 0);
        for (int k = 1; k <= 5; k++) begin
            rinc = 1'b1;
            tick();
            check($sformatf("drain%0d.rlevel", k), int'(rlevel), 5 - k);
            check($sformatf("drain%0d.raddr", k), int'(raddr), k);
            check($sformatf("drain%0d.rptr", k), int'(rptr), int'(gray(k)));
            check($sformatf("drain%0d.rempty", k), int'(rempty), (k == 5) ? 1 : 0);
        end

        // Reads while empty: the pointer holds and underflow sets and sticks.
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("uf%0d.raddr", k), int'(raddr), 5);
            check($sformatf("uf%0d.rptr", k), int'(rptr), int'(gray(5)));
            check($sformatf("uf%0d.runderflow", k), int'(runderflow), 1);
            check($sformatf("uf%0d.rempty", k), int'(rempty), 1);
        end
        rinc = 1'b0;
        tick();
        check("uf.sticky", int'(runderflow), 1);
        ruf_clr = 1'b1;
        tick();
        check("uf.clear", int'(runderflow), 0);
        rinc = 1'b1;
        tick();
        check("uf.set_wins", int'(runderflow), 1);
        rinc    = 1'b0;
        ruf_clr = 1'b0;
        tick();
        check("uf.hold_after", int'(runderflow), 1);
        ruf_clr = 1'b1;
        tick();
        check("uf.clear2", int'(runderflow), 0);
        ruf_clr = 1'b0;

        // Almost-empty with threshold 3 and a level of 6 (read pointer at 5).
        rae_thresh = 5'd3;
        rq2_wptr   = gray(11);
        tick();
        check("ae.rlevel", int'(rlevel), 6);
        check("ae.ralmost", int'(ralmost_empty), 0);
        for (int k = 1; k <= 6; k++) begin
            rinc = 1'b1;
            tick();
            check($sformatf("ae%0d.rlevel", k), int'(rlevel), 6 - k);
            check($sformatf("ae%0d.ralmost", k), int'(ralmost_empty), (6 - k <= 3) ? 1 : 0);
            check($sformatf("ae%0d.rempty", k), int'(rempty), (k == 6) ? 1 : 0);
        end
        rinc = 1'b0;

        // Streaming through the pointer wrap. Writes and reads arrive
        // together, so the last reads run past empty.
        wbin_m    = 11;
        rbin_m    = 11;
        empty_m   = 1'b1;
        prev_rptr = rptr;
        for (int i = 0; i < 48; i++) begin
            if (i < 40) wbin_m = (wbin_m + 1) % 32;
            rq2_wptr = gray(wbin_m);
            rinc     = (i >= 1);
            acc      = rinc && !empty_m;
            if (acc) rbin_m = (rbin_m + 1) % 32;
            lvl_m   = (wbin_m - rbin_m + 32) % 32;
            empty_m = (lvl_m == 0);
            tick();
            check($sformatf("wrap%0d.rlevel", i), int'(rlevel), lvl_m);
            check($sformatf("wrap%0d.rempty", i), int'(rempty), int'(empty_m));
            check($sformatf("wrap%0d.raddr", i), int'(raddr), rbin_m % 16);
            check($sformatf("wrap%0d.rptr", i), int'(rptr), int'(gray(rbin_m)));
            check($sformatf("wrap%0d.flips", i), $countones(rptr ^ prev_rptr), acc ? 1 : 0);
            prev_rptr = rptr;
        end
        check("wrap.final_raddr", int'(raddr), 3);
        rinc    = 1'b0;
        ruf_clr = 1'b1;
        tick();
        ruf_clr = 1'b0;
        check("wrap.uf_clear", int'(runderflow), 0);

        // Reset mid-stream at level 7. Reset beats the concurrent read.
        rq2_wptr = gray((rbin_m + 7) % 32);
        tick();
        check("mid.rlevel", int'(rlevel), 7);
        check("mid.ralmost", int'(ralmost_empty), 0);
        rrst = 1'b1;
        rinc = 1'b1;
        tick();
        check_reset_state("midrst");
        rrst     = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = '0;
        tick();
        check("post.rempty", int'(rempty), 1);

        // Full FIFO: level reaches 2**ADDR without looking empty.
        rq2_wptr = gray(16);
        tick();
        check("full.rlevel", int'(rlevel), 16);
        check("full.rempty", int'(rempty), 0);
        check("full.ralmost", int'(ralmost_empty), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
